pc_sequencer: RTL

//   Holds the architectural PC and consumes the {nextpc, pcsrc} redirect pair from the

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/pc_sequencer_if.sv
// Interface bundling the redirect inputs and the fetch-request outputs of
// pc_sequencer. The slave modport is the sequencer side; master is the
// environment (next-PC unit, hazard unit, instruction memory).
interface pc_sequencer_if;
  logic [31:0] i_nextpc;
  logic [1:0]  i_pcsrc;
  logic [31:0] i_exc_pc;
  logic        i_stall;
  logic        i_imem_ready;
  logic [31:0] o_pc;
  logic [31:0] o_pc_plus4;
  logic        o_imem_req;
  logic        o_valid;
  logic        o_flush;
  logic [31:0] o_epc;
  logic        o_misalign;

  modport slave (
    input  i_nextpc, i_pcsrc, i_exc_pc, i_stall, i_imem_ready,
    output o_pc, o_pc_plus4, o_imem_req, o_valid, o_flush, o_epc, o_misalign
  );

  modport master (
    output i_nextpc, i_pcsrc, i_exc_pc, i_stall, i_imem_ready,
    input  o_pc, o_pc_plus4, o_imem_req, o_valid, o_flush, o_epc, o_misalign
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC, EPC and instruction-fetch request.
// Consumes the {nextpc, pcsrc} redirect pair, buffers a redirect that
// arrives while instruction memory is not ready (HOLD), and squashes IF/ID
// with a one-cycle flush pulse after every accepted redirect.
// Optional build macro: PC_ALIGN_CHECK_EN -- misaligned targets (pcsrc 01/10)
// trap to EXC_VECTOR with o_epc holding the offending target and a
// one-cycle o_misalign pulse. Without it, targets are forced word-aligned.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180
) (
  input logic          i_clk,
  input logic          i_rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {BOOT, FETCH, HOLD} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] pending_reg;
  logic [31:0] epc_reg;
  logic        flush_reg;
  logic        misalign_reg;
  logic        imem_req_reg;

  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] target;
  logic        misaligned;
  logic        epc_load;
  logic [31:0] epc_value;

  assign redirect = (bus.i_pcsrc != 2'b00);

  // Raw redirect target; eret reads the EPC value from before this edge.
  always_comb begin
    raw_target = 32'h0;
    case (bus.i_pcsrc)
      2'b01:   raw_target = bus.i_nextpc;
      2'b10:   raw_target = epc_reg;
      2'b11:   raw_target = EXC_VECTOR;
      default: raw_target = 32'h0;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  // A misaligned jump/eret target becomes an exception to EXC_VECTOR.
  assign misaligned = ((bus.i_pcsrc == 2'b01) || (bus.i_pcsrc == 2'b10)) &&
                      (raw_target[1:0] != 2'b00);
  assign target     = misaligned ? EXC_VECTOR : raw_target;
  assign epc_load   = (bus.i_pcsrc == 2'b11) || misaligned;
  assign epc_value  = misaligned ? raw_target : bus.i_exc_pc;
`else
  // Without the check the low two bits of any target are simply dropped.
  assign misaligned = 1'b0;
  assign target     = raw_target & ~32'h3;
  assign epc_load   = (bus.i_pcsrc == 2'b11);
  assign epc_value  = bus.i_exc_pc;
`endif

  // Sequencer FSM: PC, pending redirect, EPC and registered pulses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= BOOT;
      pc_reg       <= RESET_VECTOR;
      pending_reg  <= 32'h0;
      epc_reg      <= 32'h0;
      flush_reg    <= 1'b0;
      misalign_reg <= 1'b0;
      imem_req_reg <= 1'b0;
    end else begin
      case (state_reg)
        BOOT: begin
          flush_reg    <= 1'b0;
          misalign_reg <= 1'b0;
          imem_req_reg <= 1'b1;
          state_reg    <= FETCH;
        end
        FETCH: begin
          flush_reg    <= redirect;
          misalign_reg <= misaligned;
          if (epc_load) epc_reg <= epc_value;
          if (redirect) begin
            if (bus.i_imem_ready) begin
              pc_reg <= target;
            end else begin
              pending_reg <= target;
              state_reg   <= HOLD;
            end
          end else if (bus.i_imem_ready && !bus.i_stall) begin
            pc_reg <= pc_reg + 32'd4;
          end
        end
        HOLD: begin
          // The stale fetch at pc_reg is discarded; latest redirect wins.
          flush_reg    <= redirect;
          misalign_reg <= misaligned;
          if (epc_load) epc_reg <= epc_value;
          if (redirect) pending_reg <= target;
          if (bus.i_imem_ready) begin
            pc_reg    <= redirect ? target : pending_reg;
            state_reg <= FETCH;
          end
        end
        default: begin
          state_reg    <= BOOT;
          imem_req_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_pc       = pc_reg;
  assign bus.o_pc_plus4 = pc_reg + 32'd4;
  assign bus.o_imem_req = imem_req_reg;
  assign bus.o_valid    = (state_reg == FETCH) && bus.i_imem_ready &&
                          !bus.i_stall && !redirect;
  assign bus.o_flush    = flush_reg;
  assign bus.o_epc      = epc_reg;
  assign bus.o_misalign = misalign_reg;

endmodule
